// File: rtl/eyearch_pkg.sv
// Shared instruction-format definitions for the fetch and operand-select stages.
// Instruction word layout: [1:0] type, [5:2] opcode, [31:6] operands.
package eyearch_pkg;

    localparam int INST_W       = 32;
    localparam int ADDR_W       = 32;

    localparam int TYPE_LSB     = 0;
    localparam int TYPE_MSB     = 1;
    localparam int OPCODE_LSB   = 2;
    localparam int OPCODE_MSB   = 5;
    localparam int OPERANDS_LSB = 6;
    localparam int OPERANDS_MSB = 31;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        S_TYPE = 2'b01,
        I_TYPE = 2'b10,
        B_TYPE = 2'b11
    } inst_type_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] word;
    } fetch_entry_t;

    function automatic inst_type_e inst_type(input logic [INST_W-1:0] w);
        return inst_type_e'(w[TYPE_MSB:TYPE_LSB]);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, word} entries between the imem response port and decode.
// Flush has priority over push/pop in the same cycle.
module fetch_queue
    import eyearch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PW'(1);
            end
            if (pop)
                rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, in-order imem requests, response queue, redirect flush.
// Optional macro FETCH_BYPASS_EN presents a response to decode in its arrival cycle when the queue is empty.
module fetch_unit
    import eyearch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [1:0]  dec_inst_type,
    output logic [3:0]  dec_opcode,
    output logic [25:0] dec_inst_operands,
    output logic [31:0] dec_pc
);

    localparam int            CW    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH = (CW+1)'(QUEUE_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0]     out_q, out_d, drop_q, drop_d, q_count;
    logic [CW:0]       in_flight;
    logic              req_fire, rsp_drop, rsp_keep, byp, dec_fire;
    logic              q_push, q_pop, q_empty, q_full;
    fetch_entry_t      q_head, pres, rsp_entry;

    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign in_flight = {1'b0, q_count} + {1'b0, out_q};

    // Slots are reserved at issue time, so a queue push can never overflow.
    assign imem_req_valid = !rst && !redirect_valid && !q_full && (in_flight < DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
    assign rsp_keep  = imem_rsp_valid && (drop_q == '0);
    assign rsp_entry = '{pc: rsp_pc_q, word: imem_rsp_data};

`ifdef FETCH_BYPASS_EN
    assign byp = q_empty && rsp_keep;
`else
    assign byp = 1'b0;
`endif

    assign pres     = q_empty ? rsp_entry : q_head;
    assign dec_valid = (!q_empty || byp) && !redirect_valid;
    assign dec_fire = dec_valid && dec_ready;
    assign q_pop    = dec_fire && !q_empty;
    assign q_push   = rsp_keep && !redirect_valid && !(byp && dec_ready);

    assign dec_inst_type     = dec_valid ? pres.word[TYPE_MSB:TYPE_LSB]         : '0;
    assign dec_opcode        = dec_valid ? pres.word[OPCODE_MSB:OPCODE_LSB]     : '0;
    assign dec_inst_operands = dec_valid ? pres.word[OPERANDS_MSB:OPERANDS_LSB] : '0;
    assign dec_pc            = dec_valid ? pres.pc                              : '0;

    // rsp_pc tracks the PC of the next response that will be kept; responses return in order.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q - CW'(rsp_drop);
        out_d    = out_q - CW'(rsp_keep) + CW'(req_fire);
        if (req_fire)
            pc_d = pc_q + 32'd4;
        if (rsp_keep)
            rsp_pc_d = rsp_pc_q + 32'd4;
        if (redirect_valid) begin
            drop_d   = drop_d + out_d;
            out_d    = '0;
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (rsp_entry),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order imem model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [1:0]  dec_inst_type;
    logic [3:0]  dec_opcode;
    logic [25:0] dec_inst_operands;
    logic [31:0] dec_pc;

    fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst_type(dec_inst_type), .dec_opcode(dec_opcode),
        .dec_inst_operands(dec_inst_operands), .dec_pc(dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } pend_t;

    pend_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] dpc_log[$], dword_log[$];
    logic [1:0]  dtype_log[$];
    logic [3:0]  dopc_log[$];
    logic [25:0] dopnd_log[$];

    int n_chk = 0, n_pass = 0;
    int cyc, lat, first_dec;
    logic dec_rdy, mem_rdy_mode, redir;
    logic [31:0] redir_pc;
    logic last_req_valid, last_dec_valid;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST_DEC = 2;
`else
    localparam int FIRST_DEC = 3;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'hABCD_1239 : (a ^ 32'h1357_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One clock cycle: drive at negedge, sample #1 later, advance to next negedge.
    task automatic cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_req_ready = mem_rdy_mode ? ((cyc % 3) != 0) : 1'b1;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        dec_ready      = dec_rdy;
        #1;
        last_req_valid = imem_req_valid;
        last_dec_valid = dec_valid;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
            req_log.push_back(imem_req_addr);
        end
        if (dec_valid && first_dec == 0) first_dec = cyc;
        if (dec_valid && dec_ready) begin
            dpc_log.push_back(dec_pc);
            dword_log.push_back({dec_inst_operands, dec_opcode, dec_inst_type});
            dtype_log.push_back(dec_inst_type);
            dopc_log.push_back(dec_opcode);
            dopnd_log.push_back(dec_inst_operands);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redir = 1'b0; redir_pc = '0; dec_rdy = 1'b1; mem_rdy_mode = 1'b0; lat = 1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
        pend.delete(); req_log.delete(); dpc_log.delete(); dword_log.delete();
        dtype_log.delete(); dopc_log.delete(); dopnd_log.delete();
        first_dec = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_fields", {dec_inst_type, dec_opcode, dec_inst_operands}, 0);
        chk("rst_dec_pc", dec_pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // Streaming, latency 1, decode always ready
        do_reset();
        run(12);
        chk("first_dec_cycle", first_dec, FIRST_DEC);
        chk("stream_req_count", req_log.size(), 12);
        chk("stream_dec_count", dpc_log.size(), 13 - FIRST_DEC);
        if (req_log.size() >= 6)
            for (int k = 0; k < 6; k++) chk($sformatf("stream_addr%0d", k), req_log[k], 32'(4 * k));
        if (dpc_log.size() >= 8)
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("stream_pc%0d", k), dpc_log[k], 32'(4 * k));
                chk($sformatf("stream_word%0d", k), dword_log[k], mem_word(32'(4 * k)));
            end
        if (dpc_log.size() >= 3) begin
            chk("field_type", dtype_log[2], 2'b01);
            chk("field_opcode", dopc_log[2], 4'hE);
            chk("field_operands", dopnd_log[2], 26'h2AF_3448);
        end

        // Decode stalled: exactly QUEUE_DEPTH requests, then drain in order
        do_reset();
        dec_rdy = 1'b0;
        run(10);
        chk("stall_req_count", req_log.size(), 4);
        chk("stall_req_valid", last_req_valid, 0);
        chk("stall_dec_valid", last_dec_valid, 1);
        chk("stall_dec_pc", dec_pc, 32'h0);
        dec_rdy = 1'b1;
        run(4);
        chk("drain_count", dpc_log.size(), 4);
        if (dpc_log.size() >= 4)
            for (int k = 0; k < 4; k++) chk($sformatf("drain_pc%0d", k), dpc_log[k], 32'(4 * k));

        // Latency 3, redirect with 3 outstanding and a response in the redirect cycle
        do_reset();
        lat = 3;
        run(3);
        redir = 1'b1; redir_pc = 32'h0000_1002;
        chk("redir_rsp_same_cycle", (pend.size() > 0) ? pend[0].due : -1, 4);
        cycle();
        redir = 1'b0;
        chk("redir_cycle_req_valid", last_req_valid, 0);
        chk("redir_cycle_dec_valid", last_dec_valid, 0);
        chk("redir_no_dec_fire", dpc_log.size(), 0);
        run(10);
        chk("redir_req_count", req_log.size() >= 4, 1);
        if (req_log.size() >= 4) chk("redir_new_addr", req_log[3], 32'h0000_1000);
        chk("redir_dec_count", dpc_log.size() >= 2, 1);
        if (dpc_log.size() >= 2) begin
            chk("redir_first_pc", dpc_log[0], 32'h0000_1000);
            chk("redir_first_word", dword_log[0], mem_word(32'h0000_1000));
            chk("redir_second_pc", dpc_log[1], 32'h0000_1004);
            chk("redir_second_word", dword_log[1], mem_word(32'h0000_1004));
        end

        // PC wrap across 2^32 with a stuttering memory ready
        do_reset();
        mem_rdy_mode = 1'b1;
        redir = 1'b1; redir_pc = 32'hFFFF_FFF9;
        cycle();
        redir = 1'b0;
        run(14);
        chk("wrap_req_count", req_log.size() >= 4, 1);
        if (req_log.size() >= 4) begin
            chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", req_log[2], 32'h0000_0000);
            chk("wrap_addr3", req_log[3], 32'h0000_0004);
        end
        chk("wrap_dec_count", dpc_log.size() >= 3, 1);
        if (dpc_log.size() >= 3) begin
            chk("wrap_pc0", dpc_log[0], 32'hFFFF_FFF8);
            chk("wrap_pc2", dpc_log[2], 32'h0000_0000);
            chk("wrap_word2", dword_log[2], mem_word(32'h0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
